// File: rtl/gcd_pkg.sv
// Shared types and constants for the iterative GCD engine.
package gcd_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   localparam int MODE_SUB = 0;
   localparam int MODE_BIN = 1;

endpackage

// File: rtl/gcd_step.sv
// One combinational GCD iteration: subtractive Euclid or binary (Stein).
import gcd_pkg::*;

module gcd_step #(
   parameter int WIDTH = 15,
   parameter int MODE  = MODE_SUB,
   parameter int KW    = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] i_x,
   input  logic [WIDTH-1:0] i_y,
   input  logic [KW-1:0]    i_k,
   output logic [WIDTH-1:0] o_x,
   output logic [WIDTH-1:0] o_y,
   output logic [KW-1:0]    o_k,
   output logic             o_eq
);

   logic w_eq;
   logic w_xe;
   logic w_ye;

   assign w_eq = (i_x == i_y);
   assign w_xe = ~i_x[0];
   assign w_ye = ~i_y[0];
   assign o_eq = w_eq;

   if (MODE == MODE_SUB) begin : g_sub
      always_comb begin
         o_x = i_x;
         o_y = i_y;
         o_k = i_k;
         if (!w_eq) begin
            if (i_x > i_y) o_x = i_x - i_y;
            else           o_y = i_y - i_x;
         end
      end
   end else begin : g_bin
      // Common factors of two are stripped into k and restored on exit.
      always_comb begin
         o_x = i_x;
         o_y = i_y;
         o_k = i_k;
         if (!w_eq) begin
            if (w_xe && w_ye) begin
               o_x = i_x >> 1;
               o_y = i_y >> 1;
               o_k = i_k + KW'(1);
            end else if (w_xe) begin
               o_x = i_x >> 1;
            end else if (w_ye) begin
               o_y = i_y >> 1;
            end else if (i_x > i_y) begin
               o_x = i_x - i_y;
            end else begin
               o_y = i_y - i_x;
            end
         end
      end
   end

endmodule

// File: rtl/gcd_engine.sv
// Iterative GCD engine with valid/ready handshakes on both sides.
import gcd_pkg::*;

module gcd_engine #(
   parameter int WIDTH     = 15,
   parameter int MODE      = MODE_SUB,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     res,
   output logic [CNT_WIDTH-1:0] iters
);

   localparam int KW = $clog2(WIDTH);

   state_t               r_state;
   logic [WIDTH-1:0]     r_x;
   logic [WIDTH-1:0]     r_y;
   logic [KW-1:0]        r_k;
   logic [WIDTH-1:0]     r_res;
   logic [CNT_WIDTH-1:0] r_iters;

   logic [WIDTH-1:0]     w_nx;
   logic [WIDTH-1:0]     w_ny;
   logic [KW-1:0]        w_nk;
   logic                 w_eq;

   gcd_step #(
      .WIDTH (WIDTH),
      .MODE  (MODE),
      .KW    (KW)
   ) u_step (
      .i_x  (r_x),
      .i_y  (r_y),
      .i_k  (r_k),
      .o_x  (w_nx),
      .o_y  (w_ny),
      .o_k  (w_nk),
      .o_eq (w_eq)
   );

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign res       = r_res;
   assign iters     = r_iters;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_x     <= '0;
         r_y     <= '0;
         r_k     <= '0;
         r_res   <= '0;
         r_iters <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_x     <= a;
                  r_y     <= b;
                  r_k     <= '0;
                  r_iters <= '0;
                  if (a == '0 || b == '0) begin
                     r_res   <= a | b;
                     r_state <= S_DONE;
                  end else begin
                     r_state <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               // k stays zero in subtractive mode, so the shift is a no-op.
               if (w_eq) begin
                  r_res   <= r_x << r_k;
                  r_state <= S_DONE;
               end else begin
                  r_x <= w_nx;
                  r_y <= w_ny;
                  r_k <= w_nk;
                  if (r_iters != '1) r_iters <= r_iters + CNT_WIDTH'(1);
               end
            end
            S_DONE: begin
               if (out_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gcd_engine.sv
// Directed self-checking bench for gcd_engine in both modes and with a narrow counter.
module tb_gcd_engine;

   logic        clk;
   logic        reset;
   logic        iv [3];
   logic        ir [3];
   logic        ov [3];
   logic        orr [3];
   logic [14:0] av [3];
   logic [14:0] bv [3];
   logic [14:0] rs [3];
   logic [15:0] it0;
   logic [15:0] it1;
   logic [3:0]  it2;

   int n_chk;
   int n_fail;

   gcd_engine #(.WIDTH(15), .MODE(0), .CNT_WIDTH(16)) dut0 (
      .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]),
      .a(av[0]), .b(bv[0]), .out_valid(ov[0]), .out_ready(orr[0]),
      .res(rs[0]), .iters(it0));

   gcd_engine #(.WIDTH(15), .MODE(1), .CNT_WIDTH(16)) dut1 (
      .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]),
      .a(av[1]), .b(bv[1]), .out_valid(ov[1]), .out_ready(orr[1]),
      .res(rs[1]), .iters(it1));

   gcd_engine #(.WIDTH(15), .MODE(0), .CNT_WIDTH(4)) dut2 (
      .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]),
      .a(av[2]), .b(bv[2]), .out_valid(ov[2]), .out_ready(orr[2]),
      .res(rs[2]), .iters(it2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int get_it(input int d);
      case (d)
         0: return int'(it0);
         1: return int'(it1);
         default: return int'(it2);
      endcase
   endfunction

   // Reference model: plain integer arithmetic.
   function automatic int m_gcd(input int x, input int y);
      int t;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   function automatic int m_iters(input int mode, input int x, input int y);
      int n, t;
      if (x == 0 || y == 0) return 0;
      n = 0;
      if (mode == 0) begin
         // Repeated subtraction count equals the sum of Euclid quotients minus one.
         if (x < y) begin t = x; x = y; y = t; end
         while (y != 0) begin
            n += x / y;
            t = x % y;
            x = y;
            y = t;
         end
         return n - 1;
      end
      while (x != y) begin
         if (x % 2 == 0 && y % 2 == 0) begin x /= 2; y /= 2; end
         else if (x % 2 == 0) x /= 2;
         else if (y % 2 == 0) y /= 2;
         else if (x > y) x -= y;
         else y -= x;
         n++;
      end
      return n;
   endfunction

   function automatic int m_lat(input int mode, input int x, input int y);
      if (x == 0 || y == 0) return 1;
      return m_iters(mode, x, y) + 2;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic wait_done(input int d, output int lat, output bit ok);
      lat = 1;
      ok  = 1'b1;
      forever begin
         @(negedge clk);
         if (ov[d]) break;
         lat++;
         if (lat > 400) begin
            ok = 1'b0;
            break;
         end
      end
   endtask

   task automatic accept(input int d, input int x, input int y);
      @(negedge clk);
      iv[d] = 1'b1;
      av[d] = 15'(x);
      bv[d] = 15'(y);
      @(posedge clk);
      @(negedge clk);
      iv[d] = 1'b0;
   endtask

   task automatic run(input int d, input int mode, input int cw,
                      input int x, input int y);
      int lat, exp_it, sat;
      bit ok;
      orr[d] = 1'b1;
      @(negedge clk);
      chk("ready_before", int'(ir[d]), 1);
      iv[d] = 1'b1;
      av[d] = 15'(x);
      bv[d] = 15'(y);
      @(posedge clk);
      lat = 1;
      ok  = 1'b1;
      @(negedge clk);
      iv[d] = 1'b0;
      while (!ov[d]) begin
         @(negedge clk);
         lat++;
         if (lat > 400) begin ok = 1'b0; break; end
      end
      if (!ok) begin
         chk("timeout", 0, 1);
         return;
      end
      sat    = (1 << cw) - 1;
      exp_it = m_iters(mode, x, y);
      if (exp_it > sat) exp_it = sat;
      chk("latency", lat, m_lat(mode, x, y));
      chk("res", int'(rs[d]), m_gcd(x, y));
      chk("iters", get_it(d), exp_it);
      @(posedge clk);
      @(negedge clk);
      chk("ready_after_pop", int'(ir[d]), 1);
      chk("valid_after_pop", int'(ov[d]), 0);
   endtask

   typedef struct {
      int x;
      int y;
      int g;
      int n0;
      int n1;
   } vec_t;

   vec_t vt [7];

   initial begin
      int lat, r0, i0;
      bit ok;
      n_chk  = 0;
      n_fail = 0;
      reset  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         iv[i] = 1'b0; orr[i] = 1'b0; av[i] = '0; bv[i] = '0;
      end
      vt[0] = '{12, 18, 6, 2, 4};
      vt[1] = '{48, 18, 6, 4, 6};
      vt[2] = '{0, 7, 7, 0, 0};
      vt[3] = '{9, 0, 9, 0, 0};
      vt[4] = '{0, 0, 0, 0, 0};
      vt[5] = '{7, 7, 7, 0, 0};
      vt[6] = '{17, 5, 1, 6, 7};

      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk("rst_ready", int'(ir[i]), 1);
         chk("rst_valid", int'(ov[i]), 0);
         chk("rst_res", int'(rs[i]), 0);
         chk("rst_iters", get_it(i), 0);
      end

      // Pin the model against hand-computed values.
      foreach (vt[i]) begin
         chk("model_gcd", m_gcd(vt[i].x, vt[i].y), vt[i].g);
         chk("model_n0", m_iters(0, vt[i].x, vt[i].y), vt[i].n0);
         chk("model_n1", m_iters(1, vt[i].x, vt[i].y), vt[i].n1);
      end
      chk("model_lat0", m_lat(0, 12, 18), 4);
      chk("model_lat1", m_lat(1, 12, 18), 6);
      chk("model_sat", m_iters(0, 100, 1), 99);

      foreach (vt[i]) run(0, 0, 16, vt[i].x, vt[i].y);
      foreach (vt[i]) run(1, 1, 16, vt[i].x, vt[i].y);
      run(0, 0, 16, 255, 85);
      run(1, 1, 16, 255, 85);
      run(1, 1, 16, 32767, 1);

      // Back-pressure with a stray in_valid pulse while holding the result.
      orr[1] = 1'b0;
      accept(1, 12, 18);
      wait_done(1, lat, ok);
      chk("bp_done", int'(ok), 1);
      chk("bp_res", int'(rs[1]), 6);
      chk("bp_iters", get_it(1), 4);
      r0 = int'(rs[1]);
      i0 = get_it(1);
      for (int c = 0; c < 10; c++) begin
         if (c == 3) begin iv[1] = 1'b1; av[1] = 15'd3; bv[1] = 15'd9; end
         if (c == 4) iv[1] = 1'b0;
         @(negedge clk);
         chk("bp_valid", int'(ov[1]), 1);
         chk("bp_ready", int'(ir[1]), 0);
         chk("bp_res_hold", int'(rs[1]), r0);
         chk("bp_it_hold", get_it(1), i0);
      end
      iv[1]  = 1'b0;
      orr[1] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_pop_ready", int'(ir[1]), 1);
      chk("bp_pop_valid", int'(ov[1]), 0);
      repeat (3) @(negedge clk);
      chk("bp_no_ghost", int'(ir[1]), 1);
      run(1, 1, 16, 48, 18);

      // Reset in the middle of a long subtractive run.
      orr[0] = 1'b1;
      accept(0, 32767, 1);
      repeat (4) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_ready", int'(ir[0]), 1);
      chk("mid_rst_valid", int'(ov[0]), 0);
      chk("mid_rst_res", int'(rs[0]), 0);
      chk("mid_rst_iters", get_it(0), 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_valid", int'(ov[0]), 0);
      end
      run(0, 0, 16, 5, 15);
      chk("post_rst_res", int'(rs[0]), 5);

      // Narrow counter saturates.
      run(2, 0, 4, 100, 1);
      chk("sat_iters", get_it(2), 15);
      chk("sat_res", int'(rs[2]), 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
